risc_instr_issuer: RTL and testbench
====================================

Name: risc_instr_issuer

Overview:
- Instruction-side driver for risc_top: accepts decoded ALU operations from a host over valid/ready and encodes them into 32-bit DLX-style words.
- Buffers the encoded words in a small FIFO and streams them into the core's data_in, one per cycle.
- Owns the core stall sequencing after reset and inserts NOP bubbles when it has nothing to issue.
- Captures writeback results from the core's data_out and returns them tagged with the destination register.

Parameters:
- FIFO_DEPTH, 8, instruction buffer entries (power of two, at least 2).
- PIPE_LAT, 2, cycles from issue on core_data_in to the matching result on core_data_out (counted in non-stalled cycles).
- STARTUP_STALL, 1, cycles core_stall is held high after reset deasserts.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  host offers an instruction.
- in_ready  out  1  FIFO can accept; transfer occurs when in_valid && in_ready.
- in_opcode  in  6  operation: 0 NOP, 1 ADD, 3 OR, 4 AND, 5 XOR.
- in_rd  in  5  destination GPR.
- in_rs2  in  5  source 2 GPR.
- in_rs1  in  5  source 1 GPR.
- hold  in  1  host pause request.
- core_stall  out  1  drives risc_top stall.
- core_data_in  out  32  drives risc_top data_in.
- core_data_out  in  32  risc_top data_out (writeback value).
- res_valid  out  1  one-cycle pulse; result available.
- res_rd  out  5  destination register of the result.
- res_data  out  32  result value.
- fifo_level  out  log2(FIFO_DEPTH)+1  occupied entries.
- err_illegal  out  1  sticky flag: an illegal opcode was dropped.

Behaviour:
- Encoding: word = {opcode[5:0], 5'b0, rd, rs2, rs1, 6'b0}.
  - ADD r3 = r1 + r2 encodes to 32'h04031040.
  - NOP encodes to 32'h00000000.
- Reset (asynchronous): core_stall=1, core_data_in=0, res_valid=0, res_rd=0, res_data=0, fifo_level=0, err_illegal=0, in_ready=0; FIFO and tracking state cleared.
- FSM states: RST_HOLD -> PRIME -> RUN <-> PAUSE.
  - RST_HOLD: first cycle after reset deasserts; core_stall=1. Go to PRIME.
  - PRIME: core_stall=1 for STARTUP_STALL cycles, core_data_in=0. Go to RUN.
  - RUN: core_stall=0; each cycle core_data_in is registered from the FIFO head (pop), or 0 if the FIFO is empty. hold=1 moves to PAUSE on the next edge.
  - PAUSE: core_stall=1, core_data_in holds its last value, no pop. Return to RUN on the first cycle with hold=0.
- in_ready = (state != RST_HOLD) && (FIFO not full).
  - A push and a pop in the same cycle while full is still refused: in_ready is low when full.
  - Simultaneous push/pop at any other level leaves fifo_level unchanged.
- Illegal opcode (anything other than 0, 1, 3, 4, 5): the handshake completes, the entry is not pushed, and err_illegal is set until reset.
- Host NOPs are pushed and issued like other entries but produce no result.
- Result tracking:
  - A PIPE_LAT-deep shift register of {valid, rd} advances only on cycles with core_stall=0.
  - A non-NOP issue enters with valid=1; bubbles and NOPs enter with valid=0.
  - When the tail is valid on a non-stalled cycle: res_valid=1, res_rd = tail rd, res_data = core_data_out (registered, one cycle after sampling).
- Reset mid-operation: FIFO contents and in-flight tags are discarded; no res_valid is emitted for them.
- FIFO pointers wrap modulo FIFO_DEPTH; fifo_level saturates at FIFO_DEPTH.

Optional Feature:
- Macro: RISC_HAZARD_INTERLOCK_EN.
  - Defined: in RUN, if the head's rs1 or rs2 equals the rd of a valid entry in the last 2 issued slots, issue a NOP bubble instead and keep the head. Bubbles are counted in the tracker as valid=0. The rd==0 comparison is still performed.
  - Undefined: the head is issued every RUN cycle with no dependency check; the software ordering is responsible for hazards.

Decomposition:
- Shared package risc_pkg holds:
  - opcode constants: OP_NOP=6'd0, OP_ADD=6'd1, OP_OR=6'd3, OP_AND=6'd4, OP_XOR=6'd5;
  - field bit positions: OPC 31:26, RD 20:16, RS2 15:11, RS1 10:6;
  - the NOP word constant;
  - a function encoding {op, rd, rs2, rs1} into the 32-bit word.
- One sub-module: risc_issue_fifo (synchronous FIFO with level output, asynchronous reset).

Test Plan:
- Reset release -> core_stall=1 for 1+STARTUP_STALL cycles, then 0; core_data_in=0 throughout; in_ready rises after RST_HOLD.
- Push ADD(rd3, rs2=2, rs1=1), OR(6,5,4), AND(9,8,14), XOR(12,11,10) -> core_data_in sequence 04031040, 0C062900, 10094380, 140C5A80, then 0; res_rd pulses 3, 6, 9, 12 each PIPE_LAT+1 cycles after the corresponding issue.
- Push 9 entries with no pops (hold=1) -> fifo_level=8, in_ready=0; the 9th entry is held until hold=0, then accepted.
- hold=1 for 3 cycles mid-stream -> core_stall=1 and core_data_in frozen; the res_valid pulse delayed exactly 3 cycles.
- Push opcode 2 -> not issued, err_illegal=1 until reset; later valid opcodes issue normally.
- With RISC_HAZARD_INTERLOCK_EN: ADD(3,2,1) then OR(6,3,4) -> 04031040, 00000000, 00000000, 0C0619 00 sequence (OR delayed by 2 bubbles); without the macro -> no bubbles.

Source files
------------

// File: rtl/risc_pkg.sv
// risc_pkg: shared opcodes, instruction field positions, issuer states and the word encoder.
package risc_pkg;
  localparam logic [5:0] OP_NOP = 6'd0;
  localparam logic [5:0] OP_ADD = 6'd1;
  localparam logic [5:0] OP_OR  = 6'd3;
  localparam logic [5:0] OP_AND = 6'd4;
  localparam logic [5:0] OP_XOR = 6'd5;
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RD_HI  = 20;
  localparam int RD_LO  = 16;
  localparam int RS2_HI = 15;
  localparam int RS2_LO = 11;
  localparam int RS1_HI = 10;
  localparam int RS1_LO = 6;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  typedef enum logic [1:0] {S_RST_HOLD, S_PRIME, S_RUN, S_PAUSE} state_e;
  function automatic logic [31:0] encode(input logic [5:0] op, input logic [4:0] rd, rs2, rs1);
    logic [31:0] w;
    w = NOP_WORD;
    w[OPC_HI:OPC_LO] = op;
    w[RD_HI:RD_LO] = rd;
    w[RS2_HI:RS2_LO] = rs2;
    w[RS1_HI:RS1_LO] = rs1;
    return w;
  endfunction
  function automatic logic op_legal(input logic [5:0] op);
    return op inside {OP_NOP, OP_ADD, OP_OR, OP_AND, OP_XOR};
  endfunction
endpackage

// File: rtl/risc_instr_issuer_if.sv
// risc_instr_issuer_if: host handshake, core drive and result return bundle of the issuer.
interface risc_instr_issuer_if #(parameter int FIFO_DEPTH = 8);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  logic in_valid;
  logic in_ready;
  logic [5:0] in_opcode;
  logic [4:0] in_rd;
  logic [4:0] in_rs2;
  logic [4:0] in_rs1;
  logic hold;
  logic core_stall;
  logic [31:0] core_data_in;
  logic [31:0] core_data_out;
  logic res_valid;
  logic [4:0] res_rd;
  logic [31:0] res_data;
  logic [LW-1:0] fifo_level;
  logic err_illegal;
  modport master (
    output in_valid, in_opcode, in_rd, in_rs2, in_rs1, hold, core_data_out,
    input  in_ready, core_stall, core_data_in, res_valid, res_rd, res_data, fifo_level, err_illegal
  );
  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs2, in_rs1, hold, core_data_out,
    output in_ready, core_stall, core_data_in, res_valid, res_rd, res_data, fifo_level, err_illegal
  );
endinterface

// File: rtl/risc_issue_fifo.sv
// risc_issue_fifo: synchronous FIFO with occupancy output and asynchronous reset.
module risc_issue_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] lvl_q, lvl_d;
  logic do_push, do_pop;
  assign full = lvl_q == (AW + 1)'(DEPTH);
  assign empty = lvl_q == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rp_q];
  assign level = lvl_q;
  always_comb begin
    wp_d = do_push ? wp_q + AW'(1) : wp_q;
    rp_d = do_pop ? rp_q + AW'(1) : rp_q;
    lvl_d = lvl_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
  end
  always_ff @(posedge clock)
    if (do_push) mem[wp_q] <= wdata;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      lvl_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      lvl_q <= lvl_d;
    end
endmodule

// File: rtl/risc_instr_issuer.sv
// risc_instr_issuer: encodes host ALU ops, streams them into risc_top and tags writeback results.
// Define RISC_HAZARD_INTERLOCK_EN to insert bubbles for heads that depend on the last two issues.
module risc_instr_issuer
  import risc_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int PIPE_LAT = 2,
  parameter int STARTUP_STALL = 1
) (
  input logic clock,
  input logic reset,
  risc_instr_issuer_if.slave bus
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [31:0] din_q, din_d, head, wdata, res_data_q, res_data_d;
  logic [PIPE_LAT-1:0] pv_q, pv_d;
  logic [PIPE_LAT-1:0][4:0] prd_q, prd_d;
  logic [4:0] res_rd_q, res_rd_d;
  logic res_v_q, res_v_d, err_q, err_d;
  logic run, acc, legal, push, pop, hz, full, empty, cur_v;
  logic [LW-1:0] level;
  assign run = state_q == S_RUN;
  assign acc = bus.in_valid && bus.in_ready;
  assign legal = op_legal(bus.in_opcode);
  assign push = acc && legal;
  assign pop = run && !empty && !hz;
  assign cur_v = din_q[OPC_HI:OPC_LO] != OP_NOP;
  assign wdata = encode(bus.in_opcode, bus.in_rd, bus.in_rs2, bus.in_rs1);
`ifdef RISC_HAZARD_INTERLOCK_EN
  // the word on the bus and the tracker's newest slot are the last two issues
  assign hz = !empty &&
    ((cur_v && (head[RS1_HI:RS1_LO] == din_q[RD_HI:RD_LO] || head[RS2_HI:RS2_LO] == din_q[RD_HI:RD_LO])) ||
     (pv_q[0] && (head[RS1_HI:RS1_LO] == prd_q[0] || head[RS2_HI:RS2_LO] == prd_q[0])));
`else
  assign hz = 1'b0;
`endif
  risc_issue_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .wdata(wdata),
    .rdata(head),
    .full(full),
    .empty(empty),
    .level(level)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      S_RST_HOLD: state_d = S_PRIME;
      S_PRIME: begin
        cnt_d = cnt_q + 8'd1;
        state_d = cnt_q == 8'(STARTUP_STALL - 1) ? S_RUN : S_PRIME;
      end
      default: state_d = bus.hold ? S_PAUSE : S_RUN;
    endcase
    din_d = state_q == S_PAUSE ? din_q : (pop ? head : NOP_WORD);
    // the tracker only moves on cycles the core actually consumes data_in
    pv_d = run ? PIPE_LAT'({pv_q, cur_v}) : pv_q;
    prd_d = run ? (5 * PIPE_LAT)'({prd_q, din_q[RD_HI:RD_LO]}) : prd_q;
    res_v_d = run && pv_q[PIPE_LAT-1];
    res_rd_d = res_v_d ? prd_q[PIPE_LAT-1] : res_rd_q;
    res_data_d = res_v_d ? bus.core_data_out : res_data_q;
    err_d = err_q || (acc && !legal);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= S_RST_HOLD;
      cnt_q <= '0;
      din_q <= NOP_WORD;
      pv_q <= '0;
      prd_q <= '0;
      res_v_q <= 1'b0;
      res_rd_q <= '0;
      res_data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      din_q <= din_d;
      pv_q <= pv_d;
      prd_q <= prd_d;
      res_v_q <= res_v_d;
      res_rd_q <= res_rd_d;
      res_data_q <= res_data_d;
      err_q <= err_d;
    end
  assign bus.in_ready = state_q != S_RST_HOLD && !full;
  assign bus.core_stall = !run;
  assign bus.core_data_in = din_q;
  assign bus.res_valid = res_v_q;
  assign bus.res_rd = res_rd_q;
  assign bus.res_data = res_data_q;
  assign bus.fifo_level = level;
  assign bus.err_illegal = err_q;
endmodule

// File: tb/tb_risc_instr_issuer.sv
// tb_risc_instr_issuer: directed and random stimulus checked against a queue-based issuer model.
module tb_risc_instr_issuer;
  localparam int DEPTH = 8;
  localparam int LAT = 2;
  localparam int SS = 1;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];
  logic [31:0] cons[$];
  logic [31:0] e_din, e_rdat;
  logic [4:0] e_rrd;
  bit e_rv, e_err, paused, took;
  int ph;
  logic [5:0] ops [8];

  always #5 clock = ~clock;

  risc_instr_issuer_if #(.FIFO_DEPTH(DEPTH)) b ();
  risc_instr_issuer #(.FIFO_DEPTH(DEPTH), .PIPE_LAT(LAT), .STARTUP_STALL(SS)) dut (
    .clock(clock),
    .reset(reset),
    .bus(b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic void clear();
    q.delete();
    cons.delete();
    e_din = 32'h0;
    e_rdat = 32'h0;
    e_rrd = 5'h0;
    e_rv = 1'b0;
    e_err = 1'b0;
    paused = 1'b0;
    ph = 0;
  endfunction

  task automatic check_now();
    chk("core_stall", 32'(b.core_stall), 32'(ph < 1 + SS || paused));
    chk("core_data_in", b.core_data_in, e_din);
    chk("in_ready", 32'(b.in_ready), 32'(ph != 0 && q.size() < DEPTH));
    chk("fifo_level", 32'(b.fifo_level), q.size());
    chk("err_illegal", 32'(b.err_illegal), 32'(e_err));
    chk("res_valid", 32'(b.res_valid), 32'(e_rv));
    if (e_rv) begin
      chk("res_rd", 32'(b.res_rd), 32'(e_rrd));
      chk("res_data", b.res_data, e_rdat);
    end
  endtask

`ifdef RISC_HAZARD_INTERLOCK_EN
  function automatic bit dep(input logic [31:0] w);
    for (int k = 1; k <= 2; k++)
      if (cons.size() >= k && cons[cons.size()-k][31:26] != 6'd0 &&
          (cons[cons.size()-k][20:16] == w[10:6] || cons[cons.size()-k][20:16] == w[15:11]))
        return 1'b1;
    return 1'b0;
  endfunction
`endif

  // one clock: check the current cycle, drive inputs, advance the model, move to the next negedge
  task automatic step(input bit v, input logic [5:0] op, input logic [4:0] rd, rs2, rs1, input bit h);
    logic [31:0] nd, cdo;
    int n;
    bit run, acc, nrv;
    check_now();
    cdo = $urandom();
    b.in_valid = v;
    b.in_opcode = op;
    b.in_rd = rd;
    b.in_rs2 = rs2;
    b.in_rs1 = rs1;
    b.hold = h;
    b.core_data_out = cdo;
    run = ph >= 1 + SS && !paused;
    acc = v && ph != 0 && q.size() < DEPTH;
    nd = ph < 1 + SS ? 32'h0 : e_din;
    nrv = 1'b0;
    if (run) begin
      n = cons.size();
      cons.push_back(e_din);
      if (n >= LAT && cons[n-LAT][31:26] != 6'd0) begin
        nrv = 1'b1;
        e_rrd = cons[n-LAT][20:16];
        e_rdat = cdo;
      end
      nd = 32'h0;
`ifdef RISC_HAZARD_INTERLOCK_EN
      if (q.size() > 0 && !dep(q[0])) nd = q.pop_front();
`else
      if (q.size() > 0) nd = q.pop_front();
`endif
    end
    if (acc && op inside {6'd0, 6'd1, 6'd3, 6'd4, 6'd5}) q.push_back({op, 5'b0, rd, rs2, rs1, 6'b0});
    else if (acc) e_err = 1'b1;
    paused = ph >= 1 + SS && h;
    if (ph < 1000) ph++;
    e_din = nd;
    e_rv = nrv;
    took = acc;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic mid_reset();
    #2 reset = 1'b1;
    clear();
    #1 check_now();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    ops = '{6'd1, 6'd3, 6'd4, 6'd5, 6'd0, 6'd1, 6'd3, 6'd2};
    b.in_valid = 1'b0;
    b.in_opcode = 6'd0;
    b.in_rd = 5'd0;
    b.in_rs2 = 5'd0;
    b.in_rs1 = 5'd0;
    b.hold = 1'b0;
    b.core_data_out = 32'h0;
    clear();
    repeat (2) @(negedge clock);
    check_now();
    reset = 1'b0;
    idle(4);
    step(1'b1, 6'd1, 5'd3, 5'd2, 5'd1, 1'b0);
    step(1'b1, 6'd3, 5'd6, 5'd5, 5'd4, 1'b0);
    step(1'b1, 6'd4, 5'd9, 5'd8, 5'd14, 1'b0);
    step(1'b1, 6'd5, 5'd12, 5'd11, 5'd10, 1'b0);
    idle(7);
    for (int i = 0; i < 9; i++) step(1'b1, 6'd1, 5'(i + 1), 5'd2, 5'd1, 1'b1);
    chk("full_level", 32'(b.fifo_level), 32'(DEPTH));
    chk("full_ready", 32'(b.in_ready), 32'd0);
    n = 0;
    took = 1'b0;
    while (!took && n < 10) begin
      step(1'b1, 6'd1, 5'd9, 5'd2, 5'd1, 1'b0);
      n++;
    end
    idle(14);
    step(1'b1, 6'd1, 5'd20, 5'd1, 5'd2, 1'b0);
    step(1'b1, 6'd5, 5'd21, 5'd3, 5'd4, 1'b0);
    step(1'b1, 6'd4, 5'd22, 5'd5, 5'd6, 1'b0);
    repeat (3) step(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b1);
    idle(8);
    step(1'b1, 6'd2, 5'd7, 5'd7, 5'd7, 1'b0);
    step(1'b1, 6'd1, 5'd8, 5'd1, 5'd2, 1'b0);
    idle(2);
    chk("err_sticky", 32'(b.err_illegal), 32'd1);
    idle(6);
    step(1'b1, 6'd1, 5'd3, 5'd2, 5'd1, 1'b0);
    step(1'b1, 6'd3, 5'd6, 5'd3, 5'd4, 1'b0);
    idle(8);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, ops[$urandom_range(0, 7)], 5'($urandom()), 5'($urandom()),
           5'($urandom()), $urandom_range(0, 7) == 0);
    mid_reset();
    idle(3);
    for (int i = 0; i < 120; i++)
      step($urandom_range(0, 3) != 0, ops[$urandom_range(0, 6)], 5'($urandom()), 5'($urandom()),
           5'($urandom()), $urandom_range(0, 5) == 0);
    idle(12);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
